// File: rtl/mpfifo_ctrl.sv
// Pointer/occupancy controller for a multi-port circular FIFO buffer.
// Optional sticky error flags are built when MPFIFO_ERR_FLAG_EN is defined.
module mpfifo_ctrl #(
    parameter int PAR_WRITE    = 2,
    parameter int PAR_READ     = 4,
    parameter int POINTER_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic                    buf_wr_en,
    output logic [POINTER_SIZE-1:0] wr_ptr,
    output logic [POINTER_SIZE-1:0] rd_ptr,
    output logic [POINTER_SIZE:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    wr_overflow,
    output logic                    rd_underflow
);

    localparam int DEPTH = 1 << POINTER_SIZE;
    localparam int CW    = POINTER_SIZE + 2;

    localparam logic [CW-1:0]           LP_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0]           LP_PW      = CW'(PAR_WRITE);
    localparam logic [CW-1:0]           LP_PR      = CW'(PAR_READ);
    localparam logic [POINTER_SIZE-1:0] LP_PW_STEP = POINTER_SIZE'(PAR_WRITE);
    localparam logic [POINTER_SIZE-1:0] LP_PR_STEP = POINTER_SIZE'(PAR_READ);

    logic [POINTER_SIZE-1:0] r_wr_ptr;
    logic [POINTER_SIZE-1:0] r_rd_ptr;
    logic [POINTER_SIZE:0]   r_count;

    logic            w_wr_ready;
    logic            w_rd_valid;
    logic            w_wr;
    logic            w_rd;
    logic [CW-1:0]   w_count_ext;
    logic [CW-1:0]   w_count_next;

    // Readiness looks only at the registered count, so a same-cycle write
    // never makes data visible to the read side.
    assign w_count_ext  = {1'b0, r_count};
    assign w_wr_ready   = !flush && (w_count_ext <= (LP_DEPTH - LP_PW));
    assign w_rd_valid   = !flush && (w_count_ext >= LP_PR);
    assign w_wr         = wr_valid && w_wr_ready;
    assign w_rd         = rd_ready && w_rd_valid;
    assign w_count_next = w_count_ext + (w_wr ? LP_PW : '0) - (w_rd ? LP_PR : '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LP_PW_STEP;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + LP_PR_STEP;
            end
            // The gating above keeps the sum within 0..DEPTH; the clamp only
            // guards the extra sum bit against a corrupted count.
            r_count <= (w_count_next > LP_DEPTH) ? LP_DEPTH[POINTER_SIZE:0]
                                                 : w_count_next[POINTER_SIZE:0];
        end
    end

`ifdef MPFIFO_ERR_FLAG_EN
    logic r_wr_overflow;
    logic r_rd_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            if (wr_valid && !w_wr_ready) begin
                r_wr_overflow <= 1'b1;
            end
            if (rd_ready && !w_rd_valid) begin
                r_rd_underflow <= 1'b1;
            end
        end
    end

    assign wr_overflow  = r_wr_overflow;
    assign rd_underflow = r_rd_underflow;
`else
    assign wr_overflow  = 1'b0;
    assign rd_underflow = 1'b0;
`endif

    assign wr_ready  = w_wr_ready;
    assign rd_valid  = w_rd_valid;
    assign buf_wr_en = w_wr;
    assign wr_ptr    = r_wr_ptr;
    assign rd_ptr    = r_rd_ptr;
    assign count     = r_count;
    assign full      = (w_count_ext == LP_DEPTH);
    assign empty     = (r_count == '0);

endmodule

// File: tb/tb_mpfifo_ctrl.sv
// Scoreboard bench for mpfifo_ctrl (PAR_WRITE=2, PAR_READ=4, DEPTH=8).
// Directed steps push hand-computed expectations; a negedge monitor compares.
module tb_mpfifo_ctrl;

`ifdef MPFIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic       rd_ready;
    logic       rd_valid;
    logic       buf_wr_en;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       wr_overflow;
    logic       rd_underflow;

    always #5 clk = ~clk;

    mpfifo_ctrl #(.PAR_WRITE(2), .PAR_READ(4), .POINTER_SIZE(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .buf_wr_en    (buf_wr_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .wr_overflow  (wr_overflow),
        .rd_underflow (rd_underflow)
    );

    typedef struct {
        int   id;
        logic wrr;
        logic rdv;
        logic bwe;
        int   wp;
        int   rp;
        int   cnt;
        logic ov;
        logic un;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_id = 0;

    task automatic chk(input string name, input int id, input int got, input int want);
        n_total++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0d expected %0d", name, id, got, want);
        end
    endtask

    // inputs for this cycle, then the outputs expected while they are applied
    task automatic step(input logic rn, input logic fl, input logic wv, input logic rr,
                        input logic wrr, input logic rdv, input logic bwe,
                        input int wp, input int rp, input int cnt,
                        input logic ov, input logic un);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = rn;
        flush    = fl;
        wr_valid = wv;
        rd_ready = rr;
        step_id++;
        e.id  = step_id;
        e.wrr = wrr;
        e.rdv = rdv;
        e.bwe = bwe;
        e.wp  = wp;
        e.rp  = rp;
        e.cnt = cnt;
        e.ov  = ov & ERR_EN;
        e.un  = un & ERR_EN;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_ready",     e.id, int'(wr_ready),     int'(e.wrr));
            chk("rd_valid",     e.id, int'(rd_valid),     int'(e.rdv));
            chk("buf_wr_en",    e.id, int'(buf_wr_en),    int'(e.bwe));
            chk("wr_ptr",       e.id, int'(wr_ptr),       e.wp);
            chk("rd_ptr",       e.id, int'(rd_ptr),       e.rp);
            chk("count",        e.id, int'(count),        e.cnt);
            chk("full",         e.id, int'(full),         (e.cnt == 8) ? 1 : 0);
            chk("empty",        e.id, int'(empty),        (e.cnt == 0) ? 1 : 0);
            chk("wr_overflow",  e.id, int'(wr_overflow),  int'(e.ov));
            chk("rd_underflow", e.id, int'(rd_underflow), int'(e.un));
        end
    end

    initial begin
        int budget;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);

        //   rn fl wv rr   wrr rdv bwe  wp rp cnt  ov un
        // reset state, then read at empty (underflow)
        step(1, 0, 0, 0,   1,  0,  0,   0, 0, 0,   0, 0);
        step(1, 0, 0, 1,   1,  0,  0,   0, 0, 0,   0, 0);
        // fill to full with wrap of wr_ptr, 5th write refused
        step(1, 0, 1, 0,   1,  0,  1,   0, 0, 0,   0, 1);
        step(1, 0, 1, 0,   1,  0,  1,   2, 0, 2,   0, 1);
        step(1, 0, 1, 0,   1,  1,  1,   4, 0, 4,   0, 1);
        step(1, 0, 1, 0,   1,  1,  1,   6, 0, 6,   0, 1);
        step(1, 0, 1, 0,   0,  1,  0,   0, 0, 8,   0, 1);
        step(1, 0, 0, 0,   0,  1,  0,   0, 0, 8,   1, 1);
        // flush at full with a write offered clears everything
        step(1, 1, 1, 0,   0,  0,  0,   0, 0, 8,   1, 1);
        step(1, 0, 0, 0,   1,  0,  0,   0, 0, 0,   0, 0);
        // partial read block, then full read block
        step(1, 0, 1, 0,   1,  0,  1,   0, 0, 0,   0, 0);
        step(1, 0, 0, 1,   1,  0,  0,   2, 0, 2,   0, 0);
        step(1, 0, 1, 1,   1,  0,  1,   2, 0, 2,   0, 1);
        step(1, 0, 0, 1,   1,  1,  0,   4, 0, 4,   0, 1);
        step(1, 0, 0, 0,   1,  0,  0,   4, 4, 0,   0, 1);
        // flush from a non-zero pointer state
        step(1, 1, 0, 0,   0,  0,  0,   4, 4, 0,   0, 1);
        // build count=6, wr_ptr=6, rd_ptr=0, then simultaneous transfer
        step(1, 0, 1, 0,   1,  0,  1,   0, 0, 0,   0, 0);
        step(1, 0, 1, 0,   1,  0,  1,   2, 0, 2,   0, 0);
        step(1, 0, 1, 0,   1,  1,  1,   4, 0, 4,   0, 0);
        step(1, 0, 1, 1,   1,  1,  1,   6, 0, 6,   0, 0);
        step(1, 0, 0, 0,   1,  1,  0,   0, 4, 4,   0, 0);
        step(1, 0, 1, 0,   1,  1,  1,   0, 4, 4,   0, 0);
        // flush at count=6 blocks the offered write
        step(1, 1, 1, 0,   0,  0,  0,   2, 4, 6,   0, 0);
        step(1, 0, 0, 0,   1,  0,  0,   0, 0, 0,   0, 0);
        // reset mid-traffic
        step(1, 0, 1, 0,   1,  0,  1,   0, 0, 0,   0, 0);
        step(1, 0, 1, 0,   1,  0,  1,   2, 0, 2,   0, 0);
        step(0, 0, 0, 1,   1,  1,  0,   4, 0, 4,   0, 0);
        step(1, 0, 0, 0,   1,  0,  0,   0, 0, 0,   0, 0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
